// File: rtl/recip_pipeline_if.sv
// Operand/result handshake bundle for recip_pipeline; master drives operands and out_ready, slave is the unit.
interface recip_pipeline_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int DW = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_div0;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_div0
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_div0
  );
endinterface

// File: rtl/recip_pipeline.sv
// Pipelined 1/x on {sign, exp, mantissa}: ITER+2 cycle latency, 1/cycle, whole pipe freezes while the output is stalled.
// Define RECIP_SPECIAL_EN to decode zero/Inf/NaN exponent fields; otherwise out_div0 is constant 0.
module recip_pipeline #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ITER  = 3,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  recip_pipeline_if.slave bus
);
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int F  = MAN_W + 4;
  localparam int W  = F + 2;
  localparam int EW = EXP_W + 2;

  localparam logic [EW-1:0] BIAS2 = EW'(2 * ((1 << (EXP_W - 1)) - 1));
  localparam logic [W-1:0]  C48   = W'((64'd48 << F) / 64'd17);
  localparam logic [W-1:0]  C32   = W'((64'd32 << F) / 64'd17);
  localparam logic [W-1:0]  TWO   = W'(2) << F;

  // x carries 2 integer bits and F fraction bits; exp is the signed result exponent.
  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic             pow2;
    logic [EW-1:0]    exp;
    logic [F-1:0]     dn;
    logic [W-1:0]     x;
    logic [TAG_W-1:0] tag;
`ifdef RECIP_SPECIAL_EN
    logic             spec;
    logic             div0;
    logic [DW-1:0]    spec_dat;
`endif
  } stage_t;

  function automatic logic [W-1:0] nr_step(input logic [F-1:0] dn, input logic [W-1:0] x);
    logic [W-1:0] t;
    t = TWO - W'(({{W{1'b0}}, dn} * {{F{1'b0}}, x}) >> F);
    return W'(({{W{1'b0}}, x} * {{W{1'b0}}, t}) >> F);
  endfunction

  stage_t           st_d [ITER+1];
  stage_t           st_q [ITER+1];
  logic             out_vld_q;
  logic [DW-1:0]    out_dat_d;
  logic [DW-1:0]    out_dat_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             stall;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic [MAN_W-1:0] pk_man;

  assign stall        = out_vld_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign in_exp       = bus.in_data[DW-2:MAN_W];
  assign in_man       = bus.in_data[MAN_W-1:0];

  always_comb begin
    st_d[0]      = '0;
    st_d[0].vld  = bus.in_valid;
    st_d[0].sgn  = bus.in_data[DW-1];
    st_d[0].tag  = bus.in_tag;
    st_d[0].pow2 = (in_man == '0);
    st_d[0].dn   = {1'b1, in_man, 3'b000};
    st_d[0].exp  = BIAS2 - {2'b00, in_exp} - {{(EW-1){1'b0}}, ~st_d[0].pow2};
    st_d[0].x    = C48 - W'(({{F{1'b0}}, C32} * {{W{1'b0}}, st_d[0].dn}) >> F);
`ifdef RECIP_SPECIAL_EN
    if (in_exp == '0) begin
      st_d[0].spec     = 1'b1;
      st_d[0].div0     = 1'b1;
      st_d[0].spec_dat = {bus.in_data[DW-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (in_exp == '1) begin
      st_d[0].spec     = 1'b1;
      st_d[0].spec_dat = (in_man == '0) ? {bus.in_data[DW-1], {(DW-1){1'b0}}}
                                        : {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end
`endif
    for (int k = 1; k <= ITER; k++) begin
      st_d[k]   = st_q[k-1];
      st_d[k].x = nr_step(st_q[k-1].dn, st_q[k-1].x);
    end
  end

  // Pack: exact powers of two bypass the iteration, x >= 2.0 clamps, non-positive exponent flushes.
  always_comb begin
    pk_man = st_q[ITER].x[F-1 -: MAN_W];
    if (st_q[ITER].pow2) begin
      pk_man = '0;
    end else if (st_q[ITER].x[F+1]) begin
      pk_man = '1;
    end
    if (st_q[ITER].exp[EW-1] || (st_q[ITER].exp == '0)) begin
      out_dat_d = {st_q[ITER].sgn, {(DW-1){1'b0}}};
    end else begin
      out_dat_d = {st_q[ITER].sgn, st_q[ITER].exp[EXP_W-1:0], pk_man};
    end
`ifdef RECIP_SPECIAL_EN
    if (st_q[ITER].spec) begin
      out_dat_d = st_q[ITER].spec_dat;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= ITER; k++) begin
        st_q[k] <= '0;
      end
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_tag_q <= '0;
    end else if (!stall) begin
      for (int k = 0; k <= ITER; k++) begin
        st_q[k] <= st_d[k];
      end
      out_vld_q <= st_q[ITER].vld;
      out_dat_q <= out_dat_d;
      out_tag_q <= st_q[ITER].tag;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.out_tag   = out_tag_q;

`ifdef RECIP_SPECIAL_EN
  logic out_div0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_div0_q <= 1'b0;
    end else if (!stall) begin
      out_div0_q <= st_q[ITER].div0;
    end
  end

  assign bus.out_div0 = out_div0_q;
`else
  assign bus.out_div0 = 1'b0;
`endif
endmodule
